// File: rtl/eval_sched_pkg.sv
// eval_sched_pkg: shared types, constants and the evaluation function for the
// shared-evaluator scheduler.
//   state_t   - scheduler FSM states (RUN, DRAIN, SWEEP, REPORT)
//   GOLDEN_TT - expected truth table of eval_z, bit index {x[1:0], y[1:0]}
//   eval_z    - 2-bit x / 2-bit y -> 1-bit z evaluation, structural form
package eval_sched_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWEEP,
    REPORT
  } state_t;

  // eval_z reduces to x[0] | ~y[0], which gives 4'b0101 for x[0]=0 rows
  // and 4'hF for x[0]=1 rows, repeated over x[1].
  localparam logic [15:0] GOLDEN_TT  = 16'hF5F5;
  localparam logic [3:0]  SWEEP_LAST = 4'hF;

  function automatic logic fn_a(input logic p, input logic q);
    return p & ~q;
  endfunction

  function automatic logic fn_b(input logic p, input logic q);
    return ~(p ^ q);
  endfunction

  // Kept in its structural form on purpose: the sweep exists to prove that
  // this exact network still produces the reduced truth table.
  function automatic logic eval_z(input logic [1:0] x, input logic [1:0] y);
    return (fn_a(x[0], y[0]) | fn_b(x[0], y[0])) ^
           (fn_a(x[0], y[1]) & fn_b(x[0], y[1]));
  endfunction

endpackage

// File: rtl/eval_sched_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered priority pointer.
//   clk, reset - clock and synchronous active-high reset
//   req        - per-requester request vector
//   enable     - when low no grant is issued and the pointer holds
//   grant      - one-hot-or-zero grant
//   grant_idx  - index of the granted requester (0 when no grant)
//   ptr        - current priority pointer (highest-priority requester)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic [ID_W-1:0]    ptr
);

  logic found;
  int   pos;

  // Scan upward from ptr with wrap; the first active request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (enable && !found && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = ID_W'(pos);
        found      = 1'b1;
      end
    end
  end

  // After a grant, priority moves to the requester just past the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/eval_sched.sv
// eval_sched: shared-evaluator scheduler with a built-in truth-table sweep.
//   clk, reset            - clock and synchronous active-high reset
//   req_valid/x/y/ready   - per-requester operand handshake
//   rsp_valid/ready/id/z  - registered, backpressurable response port
//   start_bist            - pulse requesting a truth-table sweep (RUN only)
//   bist_busy             - high while draining, sweeping or reporting
//   bist_done             - one-cycle pulse when the sweep result is posted
//   bist_pass             - result of the last completed sweep
module eval_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][1:0] req_x,
  input  logic [NUM_REQ-1:0][1:0] req_y,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_z,
  input  logic                    start_bist,
  output logic                    bist_busy,
  output logic                    bist_done,
  output logic                    bist_pass
);

  import eval_sched_pkg::*;

  state_t              state;
  state_t              state_next;
  logic [3:0]          cnt;
  logic [15:0]         tt;
  logic [15:0]         tt_next;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     arb_ptr;
  logic                arb_en;
  logic                any_grant;
  logic                sweep_z;
  logic                sweep_last;

  // Grants only happen in RUN and only when the response register will be
  // free at the next edge, so a stalled response is never overwritten.
  assign arb_en     = (state == RUN) && (!rsp_valid || rsp_ready);
  assign req_ready  = grant;
  assign any_grant  = |grant;
  assign sweep_z    = eval_z(cnt[3:2], cnt[1:0]);
  assign sweep_last = (state == SWEEP) && (cnt == SWEEP_LAST);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (arb_ptr)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state and status decode; busy/done come straight from the state.
  always_comb begin
    state_next = state;
    bist_busy  = 1'b1;
    bist_done  = 1'b0;
    case (state)
      RUN: begin
        bist_busy = 1'b0;
        if (start_bist) state_next = DRAIN;
      end
      DRAIN: begin
        if (!rsp_valid) state_next = SWEEP;
      end
      SWEEP: begin
        if (cnt == SWEEP_LAST) state_next = REPORT;
      end
      REPORT: begin
        bist_done  = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Truth table as it will look after this cycle's sweep write; the pass
  // flag compares against it so the last entry is included.
  always_comb begin
    tt_next      = tt;
    tt_next[cnt] = sweep_z;
  end

  // Sweep counter, truth-table capture and pass flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      tt        <= '0;
      bist_pass <= 1'b0;
    end else begin
      if (state == DRAIN) begin
        cnt <= '0;
      end else if (state == SWEEP) begin
        cnt <= cnt + 4'd1;
        tt  <= tt_next;
      end
      if (sweep_last) bist_pass <= (tt_next == GOLDEN_TT);
    end
  end

  // Response register: a new grant always loads (covers back-to-back with
  // an accept); otherwise an accept empties it and a stall holds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= 1'b0;
    end else if (any_grant) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_idx;
      rsp_z     <= eval_z(req_x[grant_idx], req_y[grant_idx]);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eval_sched.sv
// tb_eval_sched: directed self-checking bench for eval_sched (NUM_REQ=4).
module tb_eval_sched;

  import eval_sched_pkg::*;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][1:0]  req_x;
  logic [3:0][1:0]  req_y;
  logic [3:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic             rsp_z;
  logic             start_bist;
  logic             bist_busy;
  logic             bist_done;
  logic             bist_pass;

  int n_cmp;
  int n_mis;

  eval_sched #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .start_bist (start_bist),
    .bist_busy  (bist_busy),
    .bist_done  (bist_done),
    .bist_pass  (bist_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid  = 4'hF;
    rsp_ready  = 1'b1;
    start_bist = 1'b0;
    do_reset();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_mis++; $display("[TB] FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_z !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_rsp_z: got %b want 0", rsp_z); end
    n_cmp++; if (bist_busy !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_busy: got %b want 0", bist_busy); end
    n_cmp++; if (bist_done !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_done: got %b want 0", bist_done); end
    n_cmp++; if (bist_pass !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_pass: got %b want 0", bist_pass); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_mis++; $display("[TB] FAIL reset_ptr_ready: got %b want 0001", req_ready); end
    req_valid = 4'h0;
    #1;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_x[2]  = 2'b00;
    req_y[2]  = 2'b01;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_mis++; $display("[TB] FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL single_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_mis++; $display("[TB] FAIL single_id: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_z !== 1'b0) begin n_mis++; $display("[TB] FAIL single_z0: got %b want 0", rsp_z); end
    req_x[2] = 2'b01;
    req_y[2] = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_mis++; $display("[TB] FAIL single_wrap_ready: got %b want 0100", req_ready); end
    tick();
    n_cmp++; if (rsp_id !== 2'd2) begin n_mis++; $display("[TB] FAIL single_id2: got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_z !== 1'b1) begin n_mis++; $display("[TB] FAIL single_z1: got %b want 1", rsp_z); end
    req_valid = 4'b0000;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL single_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_x[i] = 2'(i);
      req_y[i] = 2'b01;
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++; if (rsp_valid !== 1'b1) begin n_mis++; $display("[TB] FAIL rot_valid[%0d]: got %b want 1", k, rsp_valid); end
      n_cmp++; if (rsp_id !== 2'(k % 4)) begin n_mis++; $display("[TB] FAIL rot_id[%0d]: got %0d want %0d", k, rsp_id, k % 4); end
      n_cmp++; if (rsp_z !== 1'(k % 2)) begin n_mis++; $display("[TB] FAIL rot_z[%0d]: got %b want %0d", k, rsp_z, k % 2); end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_mis++; $display("[TB] FAIL bp_ready0: got %b want 0000", req_ready); end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++; if (req_ready !== 4'b0000) begin n_mis++; $display("[TB] FAIL bp_ready[%0d]: got %b want 0000", j, req_ready); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_z !== 1'b1) begin
        n_mis++; $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d z=%b want v=1 id=3 z=1", j, rsp_valid, rsp_id, rsp_z);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_mis++; $display("[TB] FAIL bp_release_ready: got %b want 0001", req_ready); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 1'b0) begin
      n_mis++; $display("[TB] FAIL bp_reload: got v=%b id=%0d z=%b want v=1 id=0 z=0", rsp_valid, rsp_id, rsp_z);
    end
    tick();
    n_cmp++; if (rsp_id !== 2'd1) begin n_mis++; $display("[TB] FAIL bp_next: got %0d want 1", rsp_id); end
    req_valid = 4'h0;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_mis++; $display("[TB] FAIL bp_empty: got %b want 0", rsp_valid); end
  endtask

  task automatic test_bist_idle();
    int busy_cnt;
    int done_cnt;
    int done_at;
    int rdy_bad;
    logic pass_at_done;
    logic [3:0] ready_at_run;
    busy_cnt = 0; done_cnt = 0; done_at = -1; rdy_bad = 0;
    pass_at_done = 1'b0; ready_at_run = 4'h0;
    rsp_ready  = 1'b1;
    start_bist = 1'b1;
    tick();
    start_bist = 1'b0;
    req_valid  = 4'hF;
    #1;
    for (int m = 0; m < 22; m++) begin
      if (bist_busy === 1'b1) busy_cnt++;
      if (bist_busy === 1'b1 && req_ready !== 4'h0) rdy_bad++;
      if (bist_done === 1'b1) begin done_cnt++; done_at = m; pass_at_done = bist_pass; end
      if (m == 18) ready_at_run = req_ready;
      tick();
    end
    n_cmp++; if (busy_cnt != 18) begin n_mis++; $display("[TB] FAIL bist_busy_len: got %0d want 18", busy_cnt); end
    n_cmp++; if (done_cnt != 1 || done_at != 17) begin n_mis++; $display("[TB] FAIL bist_done_pulse: got count=%0d at=%0d want count=1 at=17", done_cnt, done_at); end
    n_cmp++; if (pass_at_done !== 1'b1) begin n_mis++; $display("[TB] FAIL bist_pass: got %b want 1", pass_at_done); end
    n_cmp++; if (rdy_bad != 0) begin n_mis++; $display("[TB] FAIL bist_ready_blocked: got %0d ready cycles want 0", rdy_bad); end
    n_cmp++; if (ready_at_run !== 4'b0100) begin n_mis++; $display("[TB] FAIL bist_ptr_kept: got %b want 0100", ready_at_run); end
    req_valid = 4'h0;
    tick();
    tick();
    n_cmp++; if (bist_pass !== 1'b1) begin n_mis++; $display("[TB] FAIL bist_pass_hold: got %b want 1", bist_pass); end
  endtask

  task automatic test_bist_stalled();
    int busy_cnt;
    int done_at;
    int late_busy;
    logic pass_at_done;
    busy_cnt = 0; done_at = -1; late_busy = 0; pass_at_done = 1'b0;
    do_reset();
    req_x[0]  = 2'b01;
    req_y[0]  = 2'b00;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 1'b1) begin
      n_mis++; $display("[TB] FAIL stall_load: got v=%b id=%0d z=%b want v=1 id=0 z=1", rsp_valid, rsp_id, rsp_z);
    end
    req_valid  = 4'h0;
    start_bist = 1'b1;
    tick();
    start_bist = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_cmp++; if (bist_busy !== 1'b1 || rsp_valid !== 1'b1) begin
        n_mis++; $display("[TB] FAIL stall_drain[%0d]: got busy=%b v=%b want busy=1 v=1", j, bist_busy, rsp_valid);
      end
      if (j < 2) tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || bist_busy !== 1'b1) begin
      n_mis++; $display("[TB] FAIL stall_accept: got v=%b busy=%b want v=0 busy=1", rsp_valid, bist_busy);
    end
    for (int m = 0; m < 20; m++) begin
      if (bist_busy === 1'b1) busy_cnt++;
      if (bist_done === 1'b1) begin done_at = m; pass_at_done = bist_pass; end
      if (m >= 18 && bist_busy !== 1'b0) late_busy++;
      if (m == 5) start_bist = 1'b1;
      tick();
      start_bist = 1'b0;
    end
    n_cmp++; if (busy_cnt != 18) begin n_mis++; $display("[TB] FAIL stall_busy_len: got %0d want 18", busy_cnt); end
    n_cmp++; if (done_at != 17) begin n_mis++; $display("[TB] FAIL stall_done_at: got %0d want 17", done_at); end
    n_cmp++; if (pass_at_done !== 1'b1) begin n_mis++; $display("[TB] FAIL stall_pass: got %b want 1", pass_at_done); end
    n_cmp++; if (late_busy != 0) begin n_mis++; $display("[TB] FAIL stall_restart_ignored: got %0d busy cycles want 0", late_busy); end
  endtask

  task automatic test_reset_mid_sweep();
    req_valid  = 4'h0;
    rsp_ready  = 1'b1;
    start_bist = 1'b1;
    tick();
    start_bist = 1'b0;
    for (int m = 0; m < 8; m++) tick();
    n_cmp++; if (dut.cnt !== 4'd7 || bist_busy !== 1'b1) begin
      n_mis++; $display("[TB] FAIL mid_sweep_pos: got cnt=%0d busy=%b want cnt=7 busy=1", dut.cnt, bist_busy);
    end
    n_cmp++; if (bist_pass !== 1'b1) begin n_mis++; $display("[TB] FAIL mid_sweep_prev_pass: got %b want 1", bist_pass); end
    reset = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_z !== 1'b0) begin
      n_mis++; $display("[TB] FAIL mrst_rsp: got v=%b id=%0d z=%b want 0/0/0", rsp_valid, rsp_id, rsp_z);
    end
    n_cmp++; if (bist_busy !== 1'b0 || bist_done !== 1'b0) begin
      n_mis++; $display("[TB] FAIL mrst_status: got busy=%b done=%b want 0/0", bist_busy, bist_done);
    end
    n_cmp++; if (bist_pass !== 1'b0) begin n_mis++; $display("[TB] FAIL mrst_pass: got %b want 0", bist_pass); end
    n_cmp++; if (dut.state !== RUN) begin n_mis++; $display("[TB] FAIL mrst_state: got %0d want %0d", dut.state, RUN); end
    n_cmp++; if (dut.cnt !== 4'd0) begin n_mis++; $display("[TB] FAIL mrst_cnt: got %0d want 0", dut.cnt); end
    n_cmp++; if (dut.u_arb.ptr !== 2'd0) begin n_mis++; $display("[TB] FAIL mrst_ptr: got %0d want 0", dut.u_arb.ptr); end
    reset = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_mis      = 0;
    reset      = 1'b1;
    req_valid  = 4'h0;
    req_x      = '0;
    req_y      = '0;
    rsp_ready  = 1'b1;
    start_bist = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bist_idle();
    test_bist_stalled();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/eval_sched.md
# eval_sched

Shared-evaluator scheduler for the 2-bit x/y → 1-bit z evaluation datapath. Up to NUM_REQ requesters post (x, y) operand pairs over valid/ready handshakes. A round-robin arbiter grants one requester per cycle to a single evaluation unit, and the result is returned with the requester ID through a registered, backpressurable response port. A built-in sweep FSM can take the evaluator offline, walk all 16 operand combinations and check the resulting truth table against the golden constant.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters; must be ≥2.
- ID_W, default $clog2(NUM_REQ): width of the response ID.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_x  in  NUM_REQ×2  per-requester x operand.
- req_y  in  NUM_REQ×2  per-requester y operand.
- req_ready  out  NUM_REQ  one-hot-or-zero grant; a transfer occurs where valid&ready.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts the response.
- rsp_id  out  ID_W  index of the granted requester.
- rsp_z  out  1  evaluation result.
- start_bist  in  1  single-cycle pulse that requests a truth-table sweep.
- bist_busy  out  1  high in DRAIN/SWEEP/REPORT.
- bist_done  out  1  one-cycle pulse at sweep completion.
- bist_pass  out  1  sweep result; holds until the next sweep completes.

## Operation
- Evaluation function, combinational:
  - a(p,q) = p & ~q
  - b(p,q) = ~(p ^ q)
  - z = (a(x0,y0) | b(x0,y0)) ^ (a(x0,y1) & b(x0,y1))
  - This reduces to z = x[0] | ~y[0]; the RTL must implement the structural form.
- FSM states:
  - RUN (reset state)
  - DRAIN
  - SWEEP
  - REPORT
- RUN:
  - Eligible when out_free = ~rsp_valid | rsp_ready.
  - If eligible, grant the first valid requester at or after priority pointer ptr, searching upward with wrap at NUM_REQ−1 → 0.
  - On a grant to i: ptr ← (i+1) mod NUM_REQ.
  - No grant: ptr unchanged.
  - Grant is captured into the response register: rsp_id=i, rsp_z=eval(req_x[i], req_y[i]), rsp_valid=1.
- Response register:
  - Holds its value while rsp_valid & ~rsp_ready.
  - Clears rsp_valid on accept with no new grant.
  - Accept and new grant in the same cycle → back-to-back; the register reloads.
- start_bist in RUN → DRAIN. The grant in that same cycle still completes. start_bist in any other state is ignored.
- DRAIN:
  - req_ready=0.
  - When rsp_valid=0 → SWEEP with cnt=0.
- SWEEP:
  - req_ready=0, rsp_valid stays 0.
  - Each cycle, operands are {x,y}=cnt[3:0] and tt[cnt] ← z; cnt increments.
  - After cnt=15 → REPORT.
- REPORT, one cycle:
  - bist_done=1.
  - bist_pass ← (tt == GOLDEN_TT).
  - Then → RUN; ptr is unchanged across the sweep.
- Reset in any state:
  - ptr=0, state=RUN, cnt=0, tt=0.
  - rsp_valid=0, rsp_id=0, rsp_z=0.
  - bist_done=0, bist_pass=0, bist_busy=0.
  - In-flight response and partial sweep are discarded.

## Timing
- Grant to response: 1 cycle. A grant at edge t makes rsp_valid=1 after edge t+1.
- Throughput is 1 response/cycle with rsp_ready held high.
- req_ready is combinational from req_valid, ptr, state, rsp_valid and rsp_ready. It is never asserted for a requester whose valid is low.
- Sweep length: start_bist at edge t with an empty response register gives:
  - DRAIN for 1 cycle
  - SWEEP for 16 cycles
  - bist_done at cycle t+18
  - RUN at t+19
- bist_pass updates on the same edge that raises bist_done.
- rsp_* outputs are registered; bist_done and bist_busy are decoded from registered state.

## Structure
- Package eval_sched_pkg holds:
  - state enum {RUN, DRAIN, SWEEP, REPORT}
  - GOLDEN_TT = 16'hF5F5 (bit index {x[1:0],y[1:0]})
  - function eval_z(x, y) returning the structural form above
- Sub-module rr_arbiter(NUM_REQ):
  - inputs: req vector, enable
  - outputs: one-hot grant, grant index, ptr register
  - takes clk/reset
- Top level holds the FSM, sweep counter/tt register and response register.

## Test plan
- Single requester: req 2 sends x=2'b00, y=2'b01, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=2, rsp_z=0. Then x=2'b01, y=2'b11 → rsp_z=1.
- All 4 requesters held valid, rsp_ready=1, from reset → grant order 0,1,2,3,0,…, one per cycle, no bubbles.
- Backpressure: rsp_ready=0 for 3 cycles with all requesters valid → req_ready=0 and rsp_* stable. Releasing rsp_ready gives same-cycle accept plus a new grant to the next requester in rotation.
- start_bist with idle requesters → bist_busy for 18 cycles, bist_done pulse at t+18, bist_pass=1. Requesters valid during the sweep see req_ready=0 throughout.
- start_bist while a response is stalled (rsp_ready=0) → stays in DRAIN until the accept, then sweeps; a second start_bist during SWEEP is ignored.
- Reset asserted mid-SWEEP (cnt=7) → next cycle all outputs at reset values, state RUN, ptr=0, bist_pass=0.
